// File: rtl/inst_byte_feeder_pkg.sv
// Shared types and defaults for the instruction-byte feeder.
package inst_byte_feeder_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [7:0]        inst_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam int unsigned FEED_WORD_BYTES = 4;
  localparam int unsigned FEED_DEPTH      = 4;

  typedef logic [8*FEED_WORD_BYTES-1:0] feed_word_t;

  // Clear the byte-offset bits of a byte address (wb is a power of 2).
  function automatic addr_t align_word(input addr_t a, input int unsigned wb);
    return a & ~addr_t'(wb - 1);
  endfunction

endpackage

// File: rtl/inst_byte_feeder_if.sv
// Redirect, instruction-memory and byte-stream signals of the feeder.
interface inst_byte_feeder_if
  import inst_byte_feeder_pkg::*;
#(
  parameter int unsigned WORD_BYTES = FEED_WORD_BYTES
) ();

  logic                    redirect;
  addr_t                   redirect_pc;
  logic                    mem_req;
  addr_t                   mem_addr;
  logic                    mem_rvalid;
  logic [8*WORD_BYTES-1:0] mem_rdata;
  logic                    out_valid;
  inst_t                   out_inst;
  addr_t                   out_pc;
  logic                    out_ready;

  // Feeder side.
  modport master (
    input  redirect, redirect_pc, mem_rvalid, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_inst, out_pc
  );

  // Environment side: memory plus fetch FSM.
  modport slave (
    output redirect, redirect_pc, mem_rvalid, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_inst, out_pc
  );

endinterface

// File: rtl/inst_word_fifo.sv
// Synchronous word FIFO with clear; push+pop on a full FIFO is legal, clear beats push.
module inst_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer, count and storage next-state.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_byte_feeder.sv
// Fetches aligned words from instruction memory and streams them out one byte per cycle.
module inst_byte_feeder
  import inst_byte_feeder_pkg::*;
#(
  parameter int unsigned WORD_BYTES = FEED_WORD_BYTES,
  parameter int unsigned DEPTH      = FEED_DEPTH,
  parameter addr_t       RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  inst_byte_feeder_if.master  bus
);

  localparam int unsigned OfsW  = $clog2(WORD_BYTES);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned WordW = 8 * WORD_BYTES;

  addr_t            fetch_addr_q, fetch_addr_d;
  addr_t            out_pc_q, out_pc_d;
  logic [OfsW-1:0]  byte_ofs_q, byte_ofs_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic [CntW-1:0]  drop_q, drop_d;

  logic [WordW-1:0] fifo_head, head_shifted;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_empty, fifo_full;
  logic             fifo_push, fifo_pop;

  logic [CntW:0]    pending;
  logic             rsp_valid, handshake, last_byte;

  inst_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WordW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.redirect),
    .push_i  (fifo_push),
    .wdata_i (bus.mem_rdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Credit, response routing and byte selection.
  always_comb begin
    // Buffered words plus outstanding requests may never exceed the FIFO depth.
    pending      = {1'b0, fifo_count} + {1'b0, inflight_q};
    bus.mem_req  = !rst && !bus.redirect && (pending < (CntW + 1)'(DEPTH));
    bus.mem_addr = fetch_addr_q;
    // A response with nothing outstanding predates a reset and is ignored.
    rsp_valid    = bus.mem_rvalid && (inflight_q != '0);
    fifo_push    = rsp_valid && !bus.redirect && (drop_q == '0);
    handshake    = bus.out_valid && bus.out_ready;
    last_byte    = (byte_ofs_q == OfsW'(WORD_BYTES - 1));
    fifo_pop     = handshake && last_byte && !bus.redirect;
    head_shifted = fifo_head >> {byte_ofs_q, 3'b000};
    bus.out_inst = head_shifted[7:0];
    bus.out_valid = !fifo_empty;
    bus.out_pc    = out_pc_q;
  end

  // Address, offset and response-accounting next-state.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    out_pc_d     = out_pc_q;
    byte_ofs_d   = byte_ofs_q;
    drop_d       = drop_q;
    inflight_d   = inflight_q + CntW'(bus.mem_req) - CntW'(rsp_valid);
    if (bus.redirect) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      drop_d       = inflight_q - CntW'(rsp_valid);
      fetch_addr_d = align_word(bus.redirect_pc, WORD_BYTES);
      byte_ofs_d   = bus.redirect_pc[OfsW-1:0];
      out_pc_d     = bus.redirect_pc;
    end else begin
      if (rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (bus.mem_req) begin
        fetch_addr_d = fetch_addr_q + addr_t'(WORD_BYTES);
      end
      if (handshake) begin
        out_pc_d   = out_pc_q + addr_t'(1);
        byte_ofs_d = byte_ofs_q + 1'b1;
      end
    end
  end

  // State registers, synchronous reset dominating redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr_q <= align_word(RESET_PC, WORD_BYTES);
      out_pc_q     <= RESET_PC;
      byte_ofs_q   <= RESET_PC[OfsW-1:0];
      inflight_q   <= '0;
      drop_q       <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      out_pc_q     <= out_pc_d;
      byte_ofs_q   <= byte_ofs_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
    end
  end

  // Design-error checks: credit must prevent overflow; drops are a subset of inflight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full && !fifo_pop));
      assert (drop_q <= inflight_q);
    end
  end

endmodule

// File: tb/tb_inst_byte_feeder.sv
// Randomised scoreboard bench for inst_byte_feeder (4-byte words, depth 4, latency-2 memory).
module tb_inst_byte_feeder;
  import inst_byte_feeder_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h1000;
  localparam int          STREAM_LEN = 512;

  typedef struct {
    int unsigned ep;
    logic [31:0] pc;
    logic [7:0]  b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_byte_feeder_if #(.WORD_BYTES(4)) bus ();

  inst_byte_feeder #(
    .WORD_BYTES (4),
    .DEPTH      (4),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_bytes = 0;
  int seg_reqs = 0;
  int seg_bytes = 0;
  int unsigned issue_ep = 0;
  int unsigned mon_ep = 0;
  exp_t exp_q[$];

  // Memory image: word at 'h1000 is fixed, everything else hashed from the address.
  function automatic logic [31:0] word_of(input logic [31:0] wa);
    if (wa == 32'h1000) return 32'h4433_2211;
    return (wa * 32'h9E37_79B1) ^ (wa >> 5) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = word_of({a[31:2], 2'b00}) >> {a[1:0], 3'b000};
    return w[7:0];
  endfunction

  // Latency-2 memory: request seen at edge E is returned in the cycle after E+1.
  logic        pipe_v = 1'b0;
  logic [31:0] pipe_a = '0;
  logic        rvalid_r = 1'b0;
  logic [31:0] rdata_r = '0;
  assign bus.mem_rvalid = rvalid_r;
  assign bus.mem_rdata  = rdata_r;

  always @(posedge clk) begin
    pipe_v   <= bus.mem_req;
    pipe_a   <= bus.mem_addr;
    rvalid_r <= pipe_v;
    rdata_r  <= word_of(pipe_a);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A stream restart: the byte sequence expected from the new start address.
  task automatic expect_stream(input logic [31:0] pc);
    issue_ep++;
    for (int i = 0; i < STREAM_LEN; i++) begin
      exp_q.push_back('{ep: issue_ep, pc: pc + 32'(i), b: ref_byte(pc + 32'(i))});
    end
  endtask

  // Monitor: every accepted byte must be the next one of the current stream.
  always @(posedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].ep < mon_ep) void'(exp_q.pop_front());
    if (rst) begin
      mon_ep++;
      seg_reqs  = 0;
      seg_bytes = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_bytes++;
        seg_bytes++;
        if (exp_q.size() == 0 || exp_q[0].ep != mon_ep) begin
          check("stream_unexpected_byte", bus.out_pc, 32'hFFFF_FFFF);
        end else begin
          check("stream_pc", bus.out_pc, exp_q[0].pc);
          check("stream_byte", 32'(bus.out_inst), 32'(exp_q[0].b));
          void'(exp_q.pop_front());
        end
      end
      if (bus.mem_req) seg_reqs++;
      if (bus.redirect) begin
        mon_ep++;
        seg_reqs  = 0;
        seg_bytes = 0;
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      expect_stream(RESET_PC);
      @(negedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    end
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    expect_stream(pc);
    @(negedge clk);
    bus.redirect = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until both latency-2 pipeline slots hold a request.
  task automatic wait_two_inflight(input string name);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 12 && !hit; k++) begin
      @(negedge clk);
      #1;
      hit = pipe_v && rvalid_r;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hit;
    logic [31:0] tgt;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;

    // Reset, then the first requests go out on consecutive cycles.
    do_reset(3);
    bus.out_ready = 1'b1;
    #1;
    check("t1_req0", 32'(bus.mem_req), 32'd1);
    check("t1_addr0", bus.mem_addr, 32'h1000);
    @(negedge clk); #1;
    check("t1_addr1", bus.mem_addr, 32'h1004);
    @(negedge clk); #1;
    check("t1_addr2", bus.mem_addr, 32'h1008);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (bus.out_valid) hit = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("t1_first_valid", 32'(hit), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      check("t1_stream_continuous", 32'(bus.out_valid), 32'd1);
    end

    // Stall: output holds, credit fills to exactly DEPTH words, requests stop.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("t2_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t2_hold_pc", bus.out_pc, exp_q[0].pc);
      check("t2_hold_inst", 32'(bus.out_inst), 32'(exp_q[0].b));
      if (i >= 5) check("t2_no_req", 32'(bus.mem_req), 32'd0);
    end
    check("t2_words_held", 32'(seg_reqs - seg_bytes / 4), 32'd4);
    bus.out_ready = 1'b1;
    run(12);

    // Redirect to 'h2003 with two responses in flight.
    do_redirect(32'h1800);
    wait_two_inflight("t3_two_inflight");
    do_redirect(32'h2003);
    #1;
    check("t3_valid_low_n1", 32'(bus.out_valid), 32'd0);
    @(negedge clk); #1;
    check("t3_valid_low_n2", 32'(bus.out_valid), 32'd0);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk); #1;
      hit = bus.out_valid;
    end
    check("t3_restart_valid", 32'(hit), 32'd1);
    run(12);

    // Redirect coincident with a memory response and a handshake.
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk); #1;
      hit = rvalid_r && bus.out_valid && bus.out_ready;
    end
    check("t4_coincident_found", 32'(hit), 32'd1);
    do_redirect(32'h6001);
    #1;
    check("t4_valid_low", 32'(bus.out_valid), 32'd0);
    run(16);

    // Three back-to-back redirects: only the last stream may appear.
    do_redirect(32'h3000);
    do_redirect(32'h4001);
    do_redirect(32'h5002);
    #1;
    check("t5_valid_low", 32'(bus.out_valid), 32'd0);
    run(20);

    // Reset mid-stream with responses in flight.
    do_redirect(32'h7000);
    wait_two_inflight("t6_two_inflight");
    do_reset(3);
    #1;
    check("t6_restart_req", 32'(bus.mem_req), 32'd1);
    check("t6_restart_addr", bus.mem_addr, 32'h1000);
    run(20);

    // Random back-pressure and redirects, including address wrap.
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
        do_redirect(tgt);
      end else begin
        @(negedge clk);
      end
    end
    bus.out_ready = 1'b1;
    run(30);

    check("bytes_seen_min", 32'(n_bytes >= 200), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
